// File: rtl/idex_stage_reg_if.sv
// ID/EX stage bus: decoded ID fields in, registered EX fields and hazard controls out.
interface idex_stage_reg_if #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 16
);
  logic               flush;
  logic [REG_W-1:0]   id_rs;
  logic [REG_W-1:0]   id_rt;
  logic [REG_W-1:0]   id_rd;
  logic [DATA_W-1:0]  id_readData1;
  logic [DATA_W-1:0]  id_readData2;
  logic [DATA_W-1:0]  id_signExt;
  logic               id_regDst;
  logic               id_aluSrc;
  logic               id_memRead;
  logic               id_memWrite;
  logic               id_memToReg;
  logic               id_regWrite;
  logic [ALUOP_W-1:0] id_aluOp;

  logic [REG_W-1:0]   idex_rs;
  logic [REG_W-1:0]   idex_rt;
  logic [REG_W-1:0]   idex_rd;
  logic [DATA_W-1:0]  idex_readData1;
  logic [DATA_W-1:0]  idex_readData2;
  logic [DATA_W-1:0]  idex_signExt;
  logic               idex_regDst;
  logic               idex_aluSrc;
  logic               idex_memRead;
  logic               idex_memWrite;
  logic               idex_memToReg;
  logic               idex_regWrite;
  logic [ALUOP_W-1:0] idex_aluOp;
  logic               idex_valid;
  logic               pc_write;
  logic               ifid_write;
  logic               stall;
  logic [CNT_W-1:0]   stall_count;

  modport master (
    output flush, id_rs, id_rt, id_rd, id_readData1, id_readData2, id_signExt,
           id_regDst, id_aluSrc, id_memRead, id_memWrite, id_memToReg, id_regWrite, id_aluOp,
    input  idex_rs, idex_rt, idex_rd, idex_readData1, idex_readData2, idex_signExt,
           idex_regDst, idex_aluSrc, idex_memRead, idex_memWrite, idex_memToReg, idex_regWrite,
           idex_aluOp, idex_valid, pc_write, ifid_write, stall, stall_count
  );

  modport slave (
    input  flush, id_rs, id_rt, id_rd, id_readData1, id_readData2, id_signExt,
           id_regDst, id_aluSrc, id_memRead, id_memWrite, id_memToReg, id_regWrite, id_aluOp,
    output idex_rs, idex_rt, idex_rd, idex_readData1, idex_readData2, idex_signExt,
           idex_regDst, idex_aluSrc, idex_memRead, idex_memWrite, idex_memToReg, idex_regWrite,
           idex_aluOp, idex_valid, pc_write, ifid_write, stall, stall_count
  );
endinterface

// File: rtl/idex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, flush bubbles
// and a saturating stall-cycle counter.
module idex_stage_reg #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  idex_stage_reg_if.slave  bus
);

  logic [REG_W-1:0]   r_rs;
  logic [REG_W-1:0]   r_rt;
  logic [REG_W-1:0]   r_rd;
  logic [DATA_W-1:0]  r_readData1;
  logic [DATA_W-1:0]  r_readData2;
  logic [DATA_W-1:0]  r_signExt;
  logic               r_regDst;
  logic               r_aluSrc;
  logic               r_memRead;
  logic               r_memWrite;
  logic               r_memToReg;
  logic               r_regWrite;
  logic [ALUOP_W-1:0] r_aluOp;
  logic               r_valid;
  logic [CNT_W-1:0]   r_stall_count;

  logic w_hazard;
  logic w_stall;
  logic w_bubble;

  // Conservative: id_rt is compared even when the ID instruction does not read rt.
  always_comb begin
    w_hazard = r_memRead && (r_rt != '0) && ((r_rt == bus.id_rs) || (r_rt == bus.id_rt));
    w_stall  = w_hazard && !bus.flush;
    w_bubble = bus.flush || w_stall;
  end

  always_ff @(posedge clk) begin
    if (reset || w_bubble) begin
      r_rs        <= '0;
      r_rt        <= '0;
      r_rd        <= '0;
      r_readData1 <= '0;
      r_readData2 <= '0;
      r_signExt   <= '0;
      r_regDst    <= 1'b0;
      r_aluSrc    <= 1'b0;
      r_memRead   <= 1'b0;
      r_memWrite  <= 1'b0;
      r_memToReg  <= 1'b0;
      r_regWrite  <= 1'b0;
      r_aluOp     <= '0;
      r_valid     <= 1'b0;
    end else begin
      r_rs        <= bus.id_rs;
      r_rt        <= bus.id_rt;
      r_rd        <= bus.id_rd;
      r_readData1 <= bus.id_readData1;
      r_readData2 <= bus.id_readData2;
      r_signExt   <= bus.id_signExt;
      r_regDst    <= bus.id_regDst;
      r_aluSrc    <= bus.id_aluSrc;
      r_memRead   <= bus.id_memRead;
      r_memWrite  <= bus.id_memWrite;
      r_memToReg  <= bus.id_memToReg;
      r_regWrite  <= bus.id_regWrite;
      r_aluOp     <= bus.id_aluOp;
      r_valid     <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_count <= '0;
    end else if (w_stall && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + CNT_W'(1);
    end
  end

  assign bus.idex_rs        = r_rs;
  assign bus.idex_rt        = r_rt;
  assign bus.idex_rd        = r_rd;
  assign bus.idex_readData1 = r_readData1;
  assign bus.idex_readData2 = r_readData2;
  assign bus.idex_signExt   = r_signExt;
  assign bus.idex_regDst    = r_regDst;
  assign bus.idex_aluSrc    = r_aluSrc;
  assign bus.idex_memRead   = r_memRead;
  assign bus.idex_memWrite  = r_memWrite;
  assign bus.idex_memToReg  = r_memToReg;
  assign bus.idex_regWrite  = r_regWrite;
  assign bus.idex_aluOp     = r_aluOp;
  assign bus.idex_valid     = r_valid;
  assign bus.stall          = w_stall;
  assign bus.pc_write       = !w_stall;
  assign bus.ifid_write     = !w_stall;
  assign bus.stall_count    = r_stall_count;

endmodule
